// File: rtl/intrapred_pkg.sv
// Shared types and constants for the intra-prediction SAD/residue datapath.
package intrapred_pkg;

  localparam int PIX_W   = 8;
  localparam int MBNUM_W = 13;
  // Wide enough for 255 * 256 pixels.
  localparam int ACC_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 4-wide blocks carry the larger mode set; 8/16-wide blocks carry three.
  function automatic int num_modes(input int mb_l);
    return (mb_l == 4) ? 8 : 3;
  endfunction

  // Clip an accumulated SAD to the 8-bit output range.
  function automatic logic [PIX_W-1:0] clip_sad(input logic [ACC_W-1:0] a);
    return (a > ACC_W'(255)) ? 8'hff : a[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/abs_diff_sat.sv
// Per-mode pixel difference: magnitude for SAD and signed residue clipped to 8 bits.
module abs_diff_sat
  import intrapred_pkg::*;
(
  input  logic [PIX_W-1:0] orig,
  input  logic [PIX_W-1:0] pred,
  output logic [PIX_W-1:0] abs_d,
  output logic [PIX_W-1:0] residue
);

  logic signed [PIX_W:0] d;
  logic        [PIX_W:0] neg_d;

  // 9-bit signed difference; |d| never exceeds 255 so it fits in 8 bits.
  always_comb begin
    d       = $signed({1'b0, orig}) - $signed({1'b0, pred});
    neg_d   = -d;
    abs_d   = d[PIX_W] ? neg_d[PIX_W-1:0] : d[PIX_W-1:0];
    residue = d[PIX_W-1:0];
    if (d > 9'sd127)
      residue = 8'h7f;
    else if (d < -9'sd128)
      residue = 8'h80;
  end

endmodule

// File: rtl/intra_sad_accumulator.sv
// Streams one macroblock (raster order, one pixel per beat), accumulating a SAD
// and capturing the clipped residue block for every candidate intra mode.
module intra_sad_accumulator
  import intrapred_pkg::*;
#(
  parameter int MB_SIZE_L = 8,
  parameter int MB_SIZE_W = 8,
  parameter int NUM_MODES = num_modes(MB_SIZE_L)
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [MBNUM_W-1:0]                               mb_in,
  input  logic                                             pix_valid,
  input  logic [PIX_W-1:0]                                 orig_pix,
  input  logic [NUM_MODES-1:0][PIX_W-1:0]                  pred_pix,
  output logic                                             busy,
  output logic                                             done,
  output logic [NUM_MODES-1:0][PIX_W-1:0]                  sads,
  output logic [NUM_MODES-1:0][MB_SIZE_L*MB_SIZE_W-1:0][PIX_W-1:0] allresidues,
  output logic [MBNUM_W-1:0]                               mbnumber
);

  localparam int N     = MB_SIZE_L * MB_SIZE_W;
  localparam int CNT_W = $clog2(N);

  state_t                            state, state_nx;
  logic [CNT_W-1:0]                  cnt;
  logic [NUM_MODES-1:0][ACC_W-1:0]   acc;
  logic [NUM_MODES-1:0][ACC_W-1:0]   acc_nx;
  logic [NUM_MODES-1:0][PIX_W-1:0]   abs_d;
  logic [NUM_MODES-1:0][PIX_W-1:0]   resid;
  logic                              start_ok;
  logic                              beat;
  logic                              last_beat;

  assign start_ok  = (state == IDLE) && start;
  assign beat      = (state == ACCUM) && pix_valid;
  assign last_beat = beat && (cnt == CNT_W'(N - 1));

  // One difference unit per mode, plus the running sum including this beat.
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
    abs_diff_sat u_ads (
      .orig    (orig_pix),
      .pred    (pred_pix[m]),
      .abs_d   (abs_d[m]),
      .residue (resid[m])
    );
    assign acc_nx[m] = acc[m] + ACC_W'(abs_d[m]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and status outputs; done is simply the one-cycle DONE state.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = ACCUM;
      ACCUM: begin
        busy = 1'b1;
        if (last_beat) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beat counter doubles as the raster index; gaps simply hold it.
  always_ff @(posedge clk) begin
    if (!reset)        cnt <= '0;
    else if (start_ok) cnt <= '0;
    else if (beat)     cnt <= cnt + 1'b1;
  end

  // Per-mode SAD accumulators, cleared at the start of each block.
  always_ff @(posedge clk) begin
    if (!reset)        acc <= '0;
    else if (start_ok) acc <= '0;
    else if (beat)     acc <= acc_nx;
  end

  // Final SADs are published on DONE entry, folding in the last beat.
  always_ff @(posedge clk) begin
    if (!reset) sads <= '0;
    else if (last_beat) begin
      for (int m = 0; m < NUM_MODES; m++)
        sads[m] <= clip_sad(acc_nx[m]);
    end
  end

  // Residue capture at the current raster position.
  always_ff @(posedge clk) begin
    if (!reset) allresidues <= '0;
    else if (beat) begin
      for (int m = 0; m < NUM_MODES; m++)
        allresidues[m][cnt] <= resid[m];
    end
  end

  // Macroblock number only moves on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset)        mbnumber <= '0;
    else if (start_ok) mbnumber <= mb_in;
  end

endmodule

// File: tb/tb_intra_sad_accumulator.sv
// Randomized bench for the SAD/residue accumulator, 8x8 and 4x4 configurations.
module tb_intra_sad_accumulator;
  import intrapred_pkg::*;

  localparam int N8 = 64;
  localparam int M8 = 3;
  localparam int N4 = 16;
  localparam int M4 = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                        start8 = 1'b0, pv8 = 1'b0;
  logic [12:0]                 mb8 = '0;
  logic [7:0]                  orig8 = '0;
  logic [M8-1:0][7:0]          pred8 = '0;
  logic                        busy8, done8;
  logic [M8-1:0][7:0]          sads8;
  logic [M8-1:0][N8-1:0][7:0]  res8;
  logic [12:0]                 mbn8;

  logic                        start4 = 1'b0, pv4 = 1'b0;
  logic [12:0]                 mb4 = '0;
  logic [7:0]                  orig4 = '0;
  logic [M4-1:0][7:0]          pred4 = '0;
  logic                        busy4, done4;
  logic [M4-1:0][7:0]          sads4;
  logic [M4-1:0][N4-1:0][7:0]  res4;
  logic [12:0]                 mbn4;

  intra_sad_accumulator #(.MB_SIZE_L(8), .MB_SIZE_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mb_in(mb8), .pix_valid(pv8),
    .orig_pix(orig8), .pred_pix(pred8), .busy(busy8), .done(done8),
    .sads(sads8), .allresidues(res8), .mbnumber(mbn8)
  );

  intra_sad_accumulator #(.MB_SIZE_L(4), .MB_SIZE_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .mb_in(mb4), .pix_valid(pv4),
    .orig_pix(orig4), .pred_pix(pred4), .busy(busy4), .done(done4),
    .sads(sads4), .allresidues(res4), .mbnumber(mbn4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus block contents (model inputs).
  int o8[N8];
  int p8[M8][N8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed difference clipped to [-128,127], as an 8-bit pattern.
  function automatic int ref_res(input int o, input int p);
    int d;
    d = o - p;
    if (d > 127)  d = 127;
    if (d < -128) d = -128;
    return d & 255;
  endfunction

  // Reference: sum of |orig - pred| over the block, clipped to 255.
  function automatic int ref_sad8(input int m);
    int s;
    s = 0;
    for (int k = 0; k < N8; k++)
      s += (o8[k] > p8[m][k]) ? o8[k] - p8[m][k] : p8[m][k] - o8[k];
    return (s > 255) ? 255 : s;
  endfunction

  // Stream one 8x8 block; optional random gaps, optional start pulses in gaps.
  task automatic run8(input int mb, input bit gaps, input bit spur);
    int lat, early, k;
    lat = 0; early = 0; k = 0;
    @(posedge clk); #1;
    start8 = 1'b1; mb8 = 13'(mb); pv8 = 1'b0;
    @(posedge clk); lat = 1; #1;
    start8 = 1'b0; mb8 = 13'(mb + 1);
    chk("busy_rise", busy8, 1);
    while (k < N8) begin
      if (done8) early++;
      if (gaps && $urandom_range(3) == 0) begin
        pv8 = 1'b0; orig8 = 8'($urandom); start8 = spur; mb8 = 13'd99;
      end else begin
        pv8 = 1'b1; orig8 = 8'(o8[k]); start8 = 1'b0;
        for (int m = 0; m < M8; m++) pred8[m] = 8'(p8[m][k]);
        k++;
      end
      @(posedge clk); lat++; #1;
    end
    pv8 = 1'b0;
    // start coincident with done must be ignored
    start8 = 1'b1; mb8 = 13'd4321;
    if (!gaps) chk("lat8", lat, N8 + 1);
    chk("done8", done8, 1);
    chk("busy8_done", busy8, 1);
    chk("early_done8", early, 0);
    chk("mbnum8", mbn8, mb);
    for (int m = 0; m < M8; m++)
      chk($sformatf("sad8_m%0d", m), sads8[m], ref_sad8(m));
    for (int m = 0; m < M8; m++)
      for (int j = 0; j < N8; j++)
        chk($sformatf("res8_m%0d_k%0d", m, j), res8[m][j], ref_res(o8[j], p8[m][j]));
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("done8_fall", done8, 0);
    chk("busy8_fall", busy8, 0);
    chk("mbnum8_hold", mbn8, mb);
  endtask

  // Scenario 2 contents: mode1 pred = orig-1, mode2 pred = orig+1.
  task automatic fill_small_diff();
    for (int k = 0; k < N8; k++) begin
      o8[k] = $urandom_range(254, 1);
      p8[0][k] = o8[k];
      p8[1][k] = o8[k] - 1;
      p8[2][k] = o8[k] + 1;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sads", sads8, 0);
    chk("rst_mbn", mbn8, 0);
    chk("rst_res", (res8 == '0), 1);
    reset = 1'b1;

    // 1: zero residue
    for (int k = 0; k < N8; k++) begin
      o8[k] = $urandom_range(255);
      for (int m = 0; m < M8; m++) p8[m][k] = o8[k];
    end
    run8(12, 1'b0, 1'b0);

    // 2: +-1 differences
    fill_small_diff();
    run8(13, 1'b0, 1'b0);
    chk("s2_sad1", sads8[1], 64);
    chk("s2_sad2", sads8[2], 64);

    // 3: saturation both ways
    for (int k = 0; k < N8; k++) begin
      if (k < 32) begin o8[k] = 255; p8[0][k] = 0;   end
      else        begin o8[k] = 0;   p8[0][k] = 200; end
      p8[1][k] = $urandom_range(255);
      p8[2][k] = $urandom_range(255);
    end
    run8(14, 1'b0, 1'b0);
    chk("s3_res_pos", res8[0][0], 8'h7f);
    chk("s3_res_neg", res8[0][40], 8'h80);

    // 4: stalls with ignored start pulses
    fill_small_diff();
    run8(37, 1'b1, 1'b1);

    // 5: reset mid-block
    @(posedge clk); #1;
    start8 = 1'b1; mb8 = 13'd50;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pv8 = 1'b1; orig8 = 8'($urandom); pred8 = '1;
      @(posedge clk); #1;
    end
    reset = 1'b0; pv8 = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_sads", sads8, 0);
    chk("mid_rst_mbn", mbn8, 0);
    chk("mid_rst_res", (res8 == '0), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_nodone", done8, 0);
    fill_small_diff();
    run8(51, 1'b0, 1'b0);

    // Random blocks with gaps
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < N8; k++) begin
        o8[k] = $urandom_range(255);
        for (int m = 0; m < M8; m++) p8[m][k] = $urandom_range(255);
      end
      run8(100 + b, 1'b1, b[0]);
    end

    // 6: 4x4, mode k pred = orig - k
    begin
      int lat;
      int o4[N4];
      @(posedge clk); #1;
      start4 = 1'b1; mb4 = 13'd77;
      @(posedge clk); lat = 1; #1;
      start4 = 1'b0;
      for (int k = 0; k < N4; k++) begin
        o4[k] = $urandom_range(255, 7);
        pv4 = 1'b1; orig4 = 8'(o4[k]);
        for (int m = 0; m < M4; m++) pred4[m] = 8'(o4[k] - m);
        @(posedge clk); lat++; #1;
      end
      pv4 = 1'b0;
      chk("lat4", lat, N4 + 1);
      chk("done4", done4, 1);
      chk("mbnum4", mbn4, 77);
      for (int m = 0; m < M4; m++) begin
        chk($sformatf("sad4_m%0d", m), sads4[m], 16 * m);
        chk($sformatf("res4_m%0d", m), res4[m][N4-1], m);
      end
      @(posedge clk); #1;
      chk("done4_fall", done4, 0);
      chk("busy4_fall", busy4, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
